// File: rtl/btn_pkg.sv
// btn_pkg: shared gesture state and result encodings
package btn_pkg;
  typedef enum logic [1:0] {IDLE, HELD, GAP, HELD2} state_t;
  typedef enum logic [1:0] {G_NONE, G_SHORT, G_LONG, G_DOUBLE} gesture_t;
endpackage

// File: rtl/sat_tick_counter.sv
// sat_tick_counter: clearable tick counter that saturates at all-ones
module sat_tick_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/button_gesture_classifier.sv
// button_gesture_classifier: classifies debounced presses as short, long or double
module button_gesture_classifier
  import btn_pkg::*;
#(
  parameter int LONG_TICKS    = 50,
  parameter int DBL_GAP_TICKS = 25,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dbt,
  input  logic             zero_to_one,
  input  logic             one_to_zero,
  output logic             short_press,
  output logic             long_press,
  output logic             double_press,
  output logic [CNT_W-1:0] hold_ticks
);
  state_t state_d, state_q;
  logic short_press_d, short_press_q, long_press_d, long_press_q, double_press_d, double_press_q;
  logic [CNT_W-1:0] hold_ticks_d, hold_ticks_q, cnt;
  logic gap_done;
  sat_tick_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state_d != state_q),
    .en (dbt),
    .cnt(cnt)
  );
  assign gap_done = dbt && cnt != '1 && cnt + CNT_W'(1) == CNT_W'(DBL_GAP_TICKS);
  always_comb begin
    state_d        = state_q;
    short_press_d  = 1'b0;
    long_press_d   = 1'b0;
    double_press_d = 1'b0;
    hold_ticks_d   = hold_ticks_q;
    case (state_q)
      IDLE:  state_d = zero_to_one ? HELD : IDLE;
      HELD:
        if (one_to_zero) begin
          hold_ticks_d = cnt;
          long_press_d = cnt >= CNT_W'(LONG_TICKS);
          state_d      = long_press_d ? IDLE : GAP;
        end
      GAP: begin
        short_press_d = !zero_to_one && gap_done;
        state_d       = zero_to_one ? HELD2 : gap_done ? IDLE : GAP;
      end
      HELD2: begin
        double_press_d = one_to_zero;
        state_d        = one_to_zero ? IDLE : HELD2;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      short_press_q  <= 1'b0;
      long_press_q   <= 1'b0;
      double_press_q <= 1'b0;
      hold_ticks_q   <= '0;
    end else begin
      state_q        <= state_d;
      short_press_q  <= short_press_d;
      long_press_q   <= long_press_d;
      double_press_q <= double_press_d;
      hold_ticks_q   <= hold_ticks_d;
    end
  end
  assign short_press  = short_press_q;
  assign long_press   = long_press_q;
  assign double_press = double_press_q;
  assign hold_ticks   = hold_ticks_q;
endmodule
